// File: rtl/mctrl_rst_sequencer.sv
// Purpose: sequences the SoC / AXI reset behind DDR calibration and drives the status LEDs.
// Latency: soc_rst_no rises CalibStableCycles+3 edges after calib_complete_i is first sampled high in WAIT.
// Backpressure: none; any reset cause or calibration loss drops soc_rst_no on the next edge.
module mctrl_rst_sequencer #(
    parameter int unsigned CalibStableCycles = 1024,
    parameter int unsigned RstHoldCycles     = 16,
    parameter int unsigned BlinkPeriodLog2   = 24,
    parameter logic        LedActiveLow      = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       mctrl_rst_i,
    input  logic       calib_complete_i,
    input  logic       btn_rst_ni,
    output logic       soc_rst_no,
    output logic [1:0] state_o,
    output logic [7:0] calib_loss_cnt_o,
    output logic [2:0] led_o
);

    // One counter serves both the hold window and the calibration qualification window.
    localparam int unsigned CntMax = (CalibStableCycles > RstHoldCycles) ? CalibStableCycles
                                                                          : RstHoldCycles;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] HoldLast  = CntW'(RstHoldCycles - 1);
    localparam logic [CntW-1:0] CalibLast = CntW'(CalibStableCycles - 1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [7:0]                 loss_q, loss_d;
    logic [BlinkPeriodLog2-1:0] hb_q, hb_d;
    logic                       soc_rst_q, soc_rst_d;
    logic [1:0]                 calib_sync_q, calib_sync_d;
    logic [1:0]                 btn_sync_q, btn_sync_d;
    logic                       calib_s;
    logic                       btn_s;
    logic                       cause;
    logic                       led_hb;
    logic [2:0]                 led_logic;

    // Two-stage synchronizers; the button idles released so it cannot fake a press out of reset.
    always_comb begin
        calib_sync_d = {calib_sync_q[0], calib_complete_i};
        btn_sync_d   = {btn_sync_q[0], btn_rst_ni};
    end

    assign calib_s = calib_sync_q[1];
    assign btn_s   = btn_sync_q[1];
    assign cause   = mctrl_rst_i | ~btn_s;

    // Next-state, shared counter, loss counter, heartbeat and reset-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        unique case (state_q)
            ST_HOLD: begin
                if (cause) begin
                    cnt_d = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_WAIT: begin
                if (cause) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (calib_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            end
            ST_STABLE: begin
                if (cause) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (!calib_s) begin
                    // A glitch throws away the partial window; WAIT restarts it from zero.
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CalibLast) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                if (cause || !calib_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    if (!calib_s && (loss_q != 8'hFF)) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
        endcase
        // Registered so the SoC reset follows RUN entry/exit on the same edge, glitch-free.
        soc_rst_d = (state_d == ST_RUN);
        hb_d      = ((state_q == ST_RUN) && (state_d == ST_RUN)) ? hb_q + BlinkPeriodLog2'(1) : '0;
    end

    // All sequencer state, cleared asynchronously by rst_ni.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            calib_sync_q <= 2'b00;
            btn_sync_q   <= 2'b11;
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            loss_q       <= 8'd0;
            hb_q         <= '0;
            soc_rst_q    <= 1'b0;
        end else begin
            calib_sync_q <= calib_sync_d;
            btn_sync_q   <= btn_sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_q       <= loss_d;
            hb_q         <= hb_d;
            soc_rst_q    <= soc_rst_d;
        end
    end

    // LED indicator: heartbeat while running, lit during hold, dark while calibrating.
    always_comb begin
        unique case (state_q)
            ST_RUN:  led_hb = hb_q[BlinkPeriodLog2-1];
            ST_HOLD: led_hb = 1'b1;
            default: led_hb = 1'b0;
        endcase
        led_logic = {led_hb, soc_rst_q, calib_s};
    end

    assign led_o            = led_logic ^ {3{LedActiveLow}};
    assign soc_rst_no       = soc_rst_q;
    assign state_o          = state_q;
    assign calib_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_mctrl_rst_sequencer.sv
// Purpose: directed self-checking bench for mctrl_rst_sequencer with small parameters.
// Latency: all expectations are hand-counted edges from each stimulus change.
// Backpressure: not applicable; inputs are driven 1 time unit after each rising edge.
module tb_mctrl_rst_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       mctrl_rst_i;
    logic       calib_complete_i;
    logic       btn_rst_ni;
    logic       soc_rst_no;
    logic [1:0] state_o;
    logic [7:0] calib_loss_cnt_o;
    logic [2:0] led_o;

    int total = 0;
    int bad   = 0;

    mctrl_rst_sequencer #(
        .CalibStableCycles(8),
        .RstHoldCycles    (4),
        .BlinkPeriodLog2  (3),
        .LedActiveLow     (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mctrl_rst_i     (mctrl_rst_i),
        .calib_complete_i(calib_complete_i),
        .btn_rst_ni      (btn_rst_ni),
        .soc_rst_no      (soc_rst_no),
        .state_o         (state_o),
        .calib_loss_cnt_o(calib_loss_cnt_o),
        .led_o           (led_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_state(input string name, input logic [1:0] exp);
        total++;
        if (state_o !== exp) begin
            bad++;
            $display("FAIL %s state_o: got %0d want %0d", name, state_o, exp);
        end
    endtask

    task automatic chk_soc(input string name, input logic exp);
        total++;
        if (soc_rst_no !== exp) begin
            bad++;
            $display("FAIL %s soc_rst_no: got %b want %b", name, soc_rst_no, exp);
        end
    endtask

    task automatic chk_loss(input string name, input logic [7:0] exp);
        total++;
        if (calib_loss_cnt_o !== exp) begin
            bad++;
            $display("FAIL %s calib_loss_cnt_o: got %0d want %0d", name, calib_loss_cnt_o, exp);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; mctrl_rst_i = 1'b0; btn_rst_ni = 1'b1; calib_complete_i = 1'b1;
        repeat (3) tick();
        chk_state("reset", 2'd0);
        chk_soc("reset", 1'b0);
        chk_loss("reset", 8'd0);
        total++;
        if (led_o !== 3'b011) begin
            bad++;
            $display("FAIL reset led_o: got %b want %b", led_o, 3'b011);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_bringup();
        tick();
        chk_state("bringup_e1", 2'd0);
        total++;
        if (led_o !== 3'b011) begin
            bad++;
            $display("FAIL bringup_hold led_o: got %b want %b", led_o, 3'b011);
        end
        repeat (2) tick();
        chk_state("bringup_e3", 2'd0);
        tick();
        chk_state("bringup_e4", 2'd1);
        total++;
        if (led_o !== 3'b110) begin
            bad++;
            $display("FAIL bringup_wait led_o: got %b want %b", led_o, 3'b110);
        end
        tick();
        chk_state("bringup_e5", 2'd2);
        repeat (7) tick();
        chk_state("bringup_e12", 2'd2);
        chk_soc("bringup_e12", 1'b0);
        total++;
        if (led_o[2] !== 1'b1) begin
            bad++;
            $display("FAIL bringup_stable led2: got %b want %b", led_o[2], 1'b1);
        end
        tick();
        chk_state("bringup_e13", 2'd3);
        chk_soc("bringup_e13", 1'b1);
        total++;
        if (led_o[1:0] !== 2'b00) begin
            bad++;
            $display("FAIL bringup_run led10: got %b want %b", led_o[1:0], 2'b00);
        end
    endtask

    task automatic test_heartbeat();
        logic exp;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            exp = (((k >> 2) & 1) != 0) ? 1'b0 : 1'b1;
            total++;
            if (led_o[2] !== exp) begin
                bad++;
                $display("FAIL heartbeat k=%0d led2: got %b want %b", k, led_o[2], exp);
            end
        end
    endtask

    task automatic test_calib_loss();
        calib_complete_i = 1'b0;
        tick();
        calib_complete_i = 1'b1;
        tick();
        chk_state("loss_e2", 2'd3);
        chk_soc("loss_e2", 1'b1);
        tick();
        chk_state("loss_e3", 2'd0);
        chk_soc("loss_e3", 1'b0);
        chk_loss("loss_e3", 8'd1);
        total++;
        if (led_o[2] !== 1'b0) begin
            bad++;
            $display("FAIL loss_hold led2: got %b want %b", led_o[2], 1'b0);
        end
        repeat (12) tick();
        chk_state("loss_e15", 2'd2);
        chk_soc("loss_e15", 1'b0);
        tick();
        chk_state("loss_e16", 2'd3);
        chk_soc("loss_e16", 1'b1);
    endtask

    task automatic test_loss_saturate();
        for (int i = 0; i < 299; i++) begin
            calib_complete_i = 1'b0;
            tick();
            calib_complete_i = 1'b1;
            repeat (15) tick();
            if (i == 252) chk_loss("sat_254", 8'd254);
        end
        chk_loss("sat_300", 8'd255);
        chk_state("sat_run", 2'd3);
    endtask

    task automatic test_button();
        btn_rst_ni = 1'b0;
        tick();
        tick();
        chk_state("btn_e2", 2'd3);
        tick();
        chk_state("btn_e3", 2'd0);
        chk_soc("btn_e3", 1'b0);
        repeat (7) tick();
        btn_rst_ni = 1'b1;
        tick();
        tick();
        chk_state("btn_e12", 2'd0);
        repeat (3) tick();
        chk_state("btn_e15", 2'd0);
        tick();
        chk_state("btn_e16", 2'd1);
        chk_loss("btn", 8'd255);
        repeat (9) tick();
        chk_state("btn_e25", 2'd3);
    endtask

    task automatic test_mctrl_wait();
        calib_complete_i = 1'b0;
        repeat (10) tick();
        chk_state("mctrl_idle", 2'd1);
        calib_complete_i = 1'b1;
        tick();
        tick();
        chk_state("mctrl_n2", 2'd1);
        mctrl_rst_i = 1'b1;
        tick();
        chk_state("mctrl_n3", 2'd0);
        mctrl_rst_i = 1'b0;
        calib_complete_i = 1'b0;
        repeat (8) tick();
        chk_state("mctrl_rewait", 2'd1);
    endtask

    task automatic test_release_glitch();
        calib_complete_i = 1'b1;
        repeat (10) tick();
        chk_state("rel_e10", 2'd2);
        chk_soc("rel_e10", 1'b0);
        tick();
        chk_state("rel_e11", 2'd3);
        chk_soc("rel_e11", 1'b1);
        calib_complete_i = 1'b0;
        repeat (10) tick();
        chk_state("glitch_idle", 2'd1);
        calib_complete_i = 1'b1;
        repeat (8) tick();
        chk_state("glitch_e8", 2'd2);
        calib_complete_i = 1'b0;
        repeat (2) tick();
        chk_state("glitch_e10", 2'd2);
        tick();
        chk_state("glitch_e11", 2'd1);
        chk_soc("glitch_e11", 1'b0);
        calib_complete_i = 1'b1;
        repeat (2) tick();
        chk_state("glitch_e13", 2'd1);
        repeat (8) tick();
        chk_state("glitch_e21", 2'd2);
        chk_soc("glitch_e21", 1'b0);
        tick();
        chk_state("glitch_e22", 2'd3);
        chk_soc("glitch_e22", 1'b1);
    endtask

    task automatic test_async_reset();
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk_soc("arst", 1'b0);
        chk_state("arst", 2'd0);
        chk_loss("arst", 8'd0);
        total++;
        if (led_o !== 3'b011) begin
            bad++;
            $display("FAIL arst led_o: got %b want %b", led_o, 3'b011);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        chk_state("arst_after", 2'd0);
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_heartbeat();
        test_calib_loss();
        test_loss_saturate();
        test_button();
        test_mctrl_wait();
        test_release_glitch();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
